// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcode constants, instruction formats,
// the decoded-slot record and the immediate extraction helper.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd6
  } fmt_t;

  // Width-independent part of the decoded slot; pc and imm are XLEN wide
  // and therefore live beside this record in the stage itself.
  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    fmt_t       fmt;
    logic       reg_wr;
    logic       mem_rd;
    logic       mem_wr;
    logic       branch;
    logic       jump;
    logic       illegal;
  } id_out_t;

  // 32-bit sign-extended immediate for a given format (0 for R/NONE).
  function automatic logic [31:0] imm_of(input logic [31:0] instr, input fmt_t fmt);
    logic [31:0] imm;
    case (fmt)
      FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm = {instr[31:12], 12'd0};
      FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Fetch-side and execute-side signals of the decode stage. The stage uses
// the slave view; the producer/consumer environment uses the master view.
interface id_stage_if #(parameter int XLEN = 32);
  import riscv_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [XLEN-1:0] imm;
  fmt_t            fmt;
  logic            reg_wr;
  logic            mem_rd;
  logic            mem_wr;
  logic            branch;
  logic            jump;
  logic            illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, opcode, rd, f3, f7, rs1, rs2, imm, fmt,
           reg_wr, mem_rd, mem_wr, branch, jump, illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, opcode, rd, f3, f7, rs1, rs2, imm, fmt,
           reg_wr, mem_rd, mem_wr, branch, jump, illegal
  );

endinterface

// File: rtl/id_fifo.sv
// Circular instruction queue with occupancy counter. Flush empties it in
// one edge; reset has priority over flush.
module id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_DEPTH = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == CNT_DEPTH);
  assign empty = (count_q == '0);

  // Next occupancy from the push/pop pair.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy state; pointers wrap naturally since DEPTH is 2^AW.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      count_q <= count_d;
    end
  end

  // Storage array; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: queue of fetched instructions, full decode of the
// queue head and a registered output slot with valid/ready toward execute.
module id_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input logic        clk,
  input logic        rst_n,
  input logic        flush,
  id_stage_if.slave  bus
);

  localparam int QW = 32 + XLEN;

  logic            fifo_full_s;
  logic            fifo_empty_s;
  logic            push_s;
  logic            load_s;
  logic [QW-1:0]   head_s;
  logic [31:0]     instr_s;
  logic [XLEN-1:0] head_pc_s;

  fmt_t            fmt_raw_s;
  logic            bad_s;
  logic            shift_imm_s;
  logic            wr_s;
  logic            mrd_s;
  logic            mwr_s;
  logic            br_s;
  logic            jmp_s;

  id_out_t         dec_d;
  id_out_t         dec_q;
  logic [XLEN-1:0] imm_d;
  logic [XLEN-1:0] imm_q;
  logic [XLEN-1:0] pc_q;
  logic            out_valid_q;

  // A full queue refuses input even when the slot is draining this cycle.
  assign bus.in_ready = !fifo_full_s;
  assign push_s       = bus.in_valid && !fifo_full_s && !flush;
  assign load_s       = !fifo_empty_s && (!out_valid_q || bus.out_ready) && !flush;
  assign instr_s      = head_s[31:0];
  assign head_pc_s    = head_s[QW-1:32];

  id_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (QW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push_s),
    .pop   (load_s),
    .wdata ({bus.in_pc, bus.in_instr}),
    .rdata (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Classify the head opcode and evaluate its legality rules.
  always_comb begin
    fmt_raw_s   = FMT_NONE;
    bad_s       = 1'b0;
    shift_imm_s = 1'b0;
    wr_s        = 1'b0;
    mrd_s       = 1'b0;
    mwr_s       = 1'b0;
    br_s        = 1'b0;
    jmp_s       = 1'b0;
    case (instr_s[6:0])
      OPC_LUI, OPC_AUIPC: begin
        fmt_raw_s = FMT_U;
        wr_s      = 1'b1;
      end
      OPC_JAL: begin
        fmt_raw_s = FMT_J;
        wr_s      = 1'b1;
        jmp_s     = 1'b1;
      end
      OPC_JALR: begin
        fmt_raw_s = FMT_I;
        wr_s      = 1'b1;
        jmp_s     = 1'b1;
        bad_s     = (instr_s[14:12] != 3'd0);
      end
      OPC_BRANCH: begin
        fmt_raw_s = FMT_B;
        br_s      = 1'b1;
        bad_s     = (instr_s[14:12] == 3'd2) || (instr_s[14:12] == 3'd3);
      end
      OPC_LOAD: begin
        fmt_raw_s = FMT_I;
        wr_s      = 1'b1;
        mrd_s     = 1'b1;
        bad_s     = (instr_s[14:12] == 3'd3) || (instr_s[14:12] == 3'd6) ||
                    (instr_s[14:12] == 3'd7);
      end
      OPC_STORE: begin
        fmt_raw_s = FMT_S;
        mwr_s     = 1'b1;
        bad_s     = (instr_s[14:12] > 3'd2);
      end
      OPC_OP_IMM: begin
        fmt_raw_s = FMT_I;
        wr_s      = 1'b1;
        if (instr_s[14:12] == 3'd1) begin
          shift_imm_s = 1'b1;
          bad_s       = (instr_s[31:25] != 7'h00);
        end else if (instr_s[14:12] == 3'd5) begin
          shift_imm_s = 1'b1;
          bad_s       = (instr_s[31:25] != 7'h00) && (instr_s[31:25] != 7'h20);
        end else begin
          shift_imm_s = 1'b0;
          bad_s       = 1'b0;
        end
      end
      OPC_OP: begin
        fmt_raw_s = FMT_R;
        wr_s      = 1'b1;
        bad_s     = !((instr_s[31:25] == 7'h00) ||
                      ((instr_s[31:25] == 7'h20) &&
                       ((instr_s[14:12] == 3'd0) || (instr_s[14:12] == 3'd5))));
      end
      OPC_MISC_MEM, OPC_SYSTEM: begin
        fmt_raw_s = FMT_I;
      end
      default: begin
        bad_s = 1'b1;
      end
    endcase
  end

  // Build the slot contents: gated fields for legal instructions, raw
  // fields with no side effects and a zero immediate for illegal ones.
  always_comb begin
    dec_d        = '0;
    imm_d        = '0;
    dec_d.opcode = instr_s[6:0];
    if (bad_s || (instr_s[1:0] != 2'b11)) begin
      dec_d.rd      = instr_s[11:7];
      dec_d.f3      = instr_s[14:12];
      dec_d.f7      = instr_s[31:25];
      dec_d.rs1     = instr_s[19:15];
      dec_d.rs2     = instr_s[24:20];
      dec_d.fmt     = FMT_NONE;
      dec_d.illegal = 1'b1;
    end else begin
      dec_d.rd      = ((fmt_raw_s == FMT_S) || (fmt_raw_s == FMT_B)) ? 5'd0 : instr_s[11:7];
      dec_d.f3      = ((fmt_raw_s == FMT_U) || (fmt_raw_s == FMT_J)) ? 3'd0 : instr_s[14:12];
      dec_d.f7      = ((fmt_raw_s == FMT_R) || shift_imm_s) ? instr_s[31:25] : 7'd0;
      dec_d.rs1     = ((fmt_raw_s == FMT_U) || (fmt_raw_s == FMT_J)) ? 5'd0 : instr_s[19:15];
      dec_d.rs2     = ((fmt_raw_s == FMT_R) || (fmt_raw_s == FMT_S) || (fmt_raw_s == FMT_B)) ?
                      instr_s[24:20] : 5'd0;
      dec_d.fmt     = fmt_raw_s;
      dec_d.reg_wr  = wr_s;
      dec_d.mem_rd  = mrd_s;
      dec_d.mem_wr  = mwr_s;
      dec_d.branch  = br_s;
      dec_d.jump    = jmp_s;
      dec_d.illegal = 1'b0;
      imm_d         = XLEN'($signed(imm_of(instr_s, fmt_raw_s)));
    end
  end

  // Output slot: reset/flush clear it, a load replaces it, a consumed slot
  // with nothing to refill just drops valid, otherwise it holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      dec_q       <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      dec_q       <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
    end else if (load_s) begin
      out_valid_q <= 1'b1;
      dec_q       <= dec_d;
      imm_q       <= imm_d;
      pc_q        <= head_pc_s;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_q;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_pc    = pc_q;
  assign bus.opcode    = dec_q.opcode;
  assign bus.rd        = dec_q.rd;
  assign bus.f3        = dec_q.f3;
  assign bus.f7        = dec_q.f7;
  assign bus.rs1       = dec_q.rs1;
  assign bus.rs2       = dec_q.rs2;
  assign bus.imm       = imm_q;
  assign bus.fmt       = dec_q.fmt;
  assign bus.reg_wr    = dec_q.reg_wr;
  assign bus.mem_rd    = dec_q.mem_rd;
  assign bus.mem_wr    = dec_q.mem_wr;
  assign bus.branch    = dec_q.branch;
  assign bus.jump      = dec_q.jump;
  assign bus.illegal   = dec_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed decode cases, back-pressure, flush, reset,
// and a randomized run against a transaction-level pipeline model.
module tb_id_stage;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  typedef logic [104:0] vec_t;

  logic clk;
  logic rst_n;
  logic flush;
  int   n_pass;
  int   n_total;
  logic [31:0] pc_ctr;
  logic [6:0]  ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                             7'h13, 7'h33, 7'h0F, 7'h73};

  id_stage_if #(.XLEN(XLEN)) bus ();

  id_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected slot contents straight from the ISA rules:
  // {pc, opcode, rd, f3, f7, rs1, rs2, imm, fmt, reg_wr, mem_rd, mem_wr, branch, jump, illegal}
  function automatic vec_t ref_dec(input logic [31:0] ins, input logic [31:0] pc);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic isu, isj, isjr, isbr, isld, isst, isopi, isop, legal, shimm;
    logic [31:0] imm;
    logic [2:0] fmt;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    isu = (op == 7'h37) || (op == 7'h17);
    isj = (op == 7'h6F); isjr = (op == 7'h67); isbr = (op == 7'h63);
    isld = (op == 7'h03); isst = (op == 7'h23); isopi = (op == 7'h13); isop = (op == 7'h33);
    legal = isu || isj || isjr || isbr || isld || isst || isopi || isop ||
            (op == 7'h0F) || (op == 7'h73);
    if (isjr && f3 != 3'd0) legal = 1'b0;
    if (isbr && (f3 == 3'd2 || f3 == 3'd3)) legal = 1'b0;
    if (isld && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) legal = 1'b0;
    if (isst && f3 > 3'd2) legal = 1'b0;
    if (isop && !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) legal = 1'b0;
    if (isopi && f3 == 3'd1 && f7 != 7'h00) legal = 1'b0;
    if (isopi && f3 == 3'd5 && !(f7 == 7'h00 || f7 == 7'h20)) legal = 1'b0;
    if (!legal)
      return {pc, op, ins[11:7], f3, f7, ins[19:15], ins[24:20], 32'd0, 3'd6, 6'b000001};
    shimm = isopi && (f3 == 3'd1 || f3 == 3'd5);
    if (isu)       begin fmt = 3'd4; imm = {ins[31:12], 12'd0}; end
    else if (isj)  begin fmt = 3'd5; imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; end
    else if (isbr) begin fmt = 3'd3; imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; end
    else if (isst) begin fmt = 3'd2; imm = {{20{ins[31]}}, ins[31:25], ins[11:7]}; end
    else if (isop) begin fmt = 3'd0; imm = 32'd0; end
    else           begin fmt = 3'd1; imm = {{20{ins[31]}}, ins[31:20]}; end
    return {pc, op,
            (isst || isbr) ? 5'd0 : ins[11:7],
            (isu || isj) ? 3'd0 : f3,
            (isop || shimm) ? f7 : 7'd0,
            (isu || isj) ? 5'd0 : ins[19:15],
            (isop || isst || isbr) ? ins[24:20] : 5'd0,
            imm, fmt,
            isu || isj || isjr || isld || isopi || isop, isld, isst, isbr, isj || isjr, 1'b0};
  endfunction

  function automatic vec_t obs();
    return {bus.out_pc, bus.opcode, bus.rd, bus.f3, bus.f7, bus.rs1, bus.rs2, bus.imm,
            3'(bus.fmt), bus.reg_wr, bus.mem_rd, bus.mem_wr, bus.branch, bus.jump, bus.illegal};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 11);
    if (k == 11) return r;
    if (r[0]) r[31:25] = r[30] ? 7'h20 : 7'h00;
    return {r[31:7], ops[k]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_instr = 32'd0; bus.in_pc = 32'd0; bus.out_ready = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else n_pass++;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready); else n_pass++;
    n_total++; if (obs() !== '0) $display("FAIL reset_slot got %h want 0", obs()); else n_pass++;
  endtask

  task automatic test_decode();
    logic [31:0] tbl [6] = '{32'hFFF00093, 32'h0020A423, 32'hFE000EE3, 32'h123452B7,
                             32'h00000000, 32'h4000D0B3};
    logic [4:0] g_rd [6], g_rs1 [6], g_rs2 [6];
    logic [31:0] g_imm [6];
    logic [2:0] g_fmt [6];
    logic [5:0] g_fl [6];
    do_reset();
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1; bus.in_instr = tbl[i]; bus.in_pc = 32'h100 + 32'(4 * i);
      bus.out_ready = 1'b1;
      step();
      bus.in_valid = 1'b0;
      n_total++; if (bus.out_valid !== 1'b0) $display("FAIL latency_early[%0d] got %b want 0", i, bus.out_valid); else n_pass++;
      step();
      n_total++; if (bus.out_valid !== 1'b1) $display("FAIL latency[%0d] got %b want 1", i, bus.out_valid); else n_pass++;
      n_total++; if (obs() !== ref_dec(tbl[i], 32'h100 + 32'(4 * i)))
        $display("FAIL decode[%0d] got %h want %h", i, obs(), ref_dec(tbl[i], 32'h100 + 32'(4 * i)));
      else n_pass++;
      g_rd[i] = bus.rd; g_rs1[i] = bus.rs1; g_rs2[i] = bus.rs2; g_imm[i] = bus.imm;
      g_fmt[i] = 3'(bus.fmt);
      g_fl[i] = {bus.reg_wr, bus.mem_rd, bus.mem_wr, bus.branch, bus.jump, bus.illegal};
    end
    step();
    n_total++; if (g_rd[0] !== 5'd1 || g_fmt[0] !== 3'd1 || g_imm[0] !== 32'hFFFFFFFF || g_fl[0] !== 6'b100000)
      $display("FAIL addi got rd=%0d fmt=%0d imm=%h fl=%b want 1 1 ffffffff 100000", g_rd[0], g_fmt[0], g_imm[0], g_fl[0]);
    else n_pass++;
    n_total++; if (g_fmt[1] !== 3'd2 || g_rs1[1] !== 5'd1 || g_rs2[1] !== 5'd2 || g_imm[1] !== 32'd8 ||
                   g_rd[1] !== 5'd0 || g_fl[1] !== 6'b001000)
      $display("FAIL sw got fmt=%0d rs1=%0d rs2=%0d imm=%h rd=%0d fl=%b want 2 1 2 8 0 001000",
               g_fmt[1], g_rs1[1], g_rs2[1], g_imm[1], g_rd[1], g_fl[1]);
    else n_pass++;
    n_total++; if (g_imm[2] !== 32'hFFFFFFFC || g_fl[2] !== 6'b000100)
      $display("FAIL beq got imm=%h fl=%b want fffffffc 000100", g_imm[2], g_fl[2]); else n_pass++;
    n_total++; if (g_imm[3] !== 32'h12345000 || g_rd[3] !== 5'd5)
      $display("FAIL lui got imm=%h rd=%0d want 12345000 5", g_imm[3], g_rd[3]); else n_pass++;
    n_total++; if (g_fl[4] !== 6'b000001 || g_fmt[4] !== 3'd6)
      $display("FAIL zero_word got fl=%b fmt=%0d want 000001 6", g_fl[4], g_fmt[4]); else n_pass++;
    n_total++; if (g_fl[5] !== 6'b100000)
      $display("FAIL sra got fl=%b want 100000", g_fl[5]); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [63:0] sent [$];
    vec_t first_v;
    int got;
    logic seen;
    do_reset();
    bus.out_ready = 1'b0; seen = 1'b0; first_v = '0;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1; bus.in_instr = rand_instr(); bus.in_pc = pc_ctr; pc_ctr += 32'd4;
      if (bus.in_ready) sent.push_back({bus.in_pc, bus.in_instr});
      step();
      if (bus.out_valid && !seen) begin first_v = obs(); seen = 1'b1; end
    end
    bus.in_valid = 1'b0;
    n_total++; if (sent.size() != DEPTH + 1) $display("FAIL bp_accepted got %0d want %0d", sent.size(), DEPTH + 1); else n_pass++;
    n_total++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready got %b want 0", bus.in_ready); else n_pass++;
    n_total++; if (bus.out_valid !== 1'b1 || obs() !== first_v)
      $display("FAIL bp_stable got %h want %h", obs(), first_v); else n_pass++;
    bus.out_ready = 1'b1; got = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.out_valid) begin
        got++;
        if (sent.size() == 0) begin
          n_total++; $display("FAIL bp_extra got item %0d want none", got);
        end else begin
          n_total++; if (obs() !== ref_dec(sent[0][31:0], sent[0][63:32]))
            $display("FAIL bp_order got %h want %h", obs(), ref_dec(sent[0][31:0], sent[0][63:32]));
          else n_pass++;
          void'(sent.pop_front());
        end
      end
      step();
    end
    n_total++; if (got != DEPTH + 1) $display("FAIL bp_drained got %0d want %0d", got, DEPTH + 1); else n_pass++;
  endtask

  task automatic fill_four();
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.in_instr = 32'h00100093 + 32'(i << 7); bus.in_pc = pc_ctr; pc_ctr += 32'd4;
      step();
    end
    bus.in_instr = 32'h7FF00113; bus.in_pc = 32'h0000BAD0;
  endtask

  task automatic test_flush();
    int seen;
    fill_four();
    flush = 1'b1;
    step();
    flush = 1'b0; bus.in_valid = 1'b0;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL flush_out_valid got %b want 0", bus.out_valid); else n_pass++;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL flush_in_ready got %b want 1", bus.in_ready); else n_pass++;
    bus.out_ready = 1'b1; seen = 0;
    for (int i = 0; i < 8; i++) begin step(); if (bus.out_valid) seen++; end
    n_total++; if (seen != 0) $display("FAIL flush_leak got %0d want 0", seen); else n_pass++;
    bus.in_valid = 1'b1; bus.in_instr = 32'h00A00513; bus.in_pc = 32'h200;
    step(); bus.in_valid = 1'b0; step();
    n_total++; if (bus.out_valid !== 1'b1 || obs() !== ref_dec(32'h00A00513, 32'h200))
      $display("FAIL flush_resume got %b %h want 1 %h", bus.out_valid, obs(), ref_dec(32'h00A00513, 32'h200));
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int seen;
    fill_four();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; bus.in_valid = 1'b0;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", bus.out_valid); else n_pass++;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready got %b want 1", bus.in_ready); else n_pass++;
    n_total++; if (obs() !== '0) $display("FAIL rst_slot got %h want 0", obs()); else n_pass++;
    bus.out_ready = 1'b1; seen = 0;
    for (int i = 0; i < 8; i++) begin step(); if (bus.out_valid) seen++; end
    n_total++; if (seen != 0) $display("FAIL rst_leak got %0d want 0", seen); else n_pass++;
  endtask

  // Transaction-level model: a bounded queue feeding a one-entry slot.
  task automatic test_random();
    logic [63:0] mq [$];
    logic [63:0] ms_item;
    logic ms_valid, ld;
    do_reset();
    ms_valid = 1'b0; ms_item = '0;
    for (int c = 0; c < 400; c++) begin
      bus.in_valid  = (c < 20) ? 1'b1 : ($urandom_range(0, 9) < 7);
      bus.out_ready = (c < 20) ? 1'b1 : ($urandom_range(0, 9) < 7);
      flush         = (c < 20) ? 1'b0 : ($urandom_range(0, 99) < 3);
      bus.in_instr  = rand_instr(); bus.in_pc = pc_ctr; pc_ctr += 32'd4;
      if (flush) begin
        mq.delete(); ms_valid = 1'b0;
      end else begin
        ld = (mq.size() > 0) && (!ms_valid || bus.out_ready);
        if (bus.in_valid && mq.size() < DEPTH) mq.push_back({bus.in_pc, bus.in_instr});
        if (ld) begin ms_item = mq.pop_front(); ms_valid = 1'b1; end
        else if (bus.out_ready) ms_valid = 1'b0;
      end
      step();
      n_total++; if (bus.out_valid !== ms_valid) $display("FAIL rnd_valid cyc %0d got %b want %b", c, bus.out_valid, ms_valid); else n_pass++;
      n_total++; if (bus.in_ready !== (mq.size() < DEPTH)) $display("FAIL rnd_in_ready cyc %0d got %b want %b", c, bus.in_ready, mq.size() < DEPTH); else n_pass++;
      if (ms_valid) begin
        n_total++; if (obs() !== ref_dec(ms_item[31:0], ms_item[63:32]))
          $display("FAIL rnd_slot cyc %0d got %h want %h", c, obs(), ref_dec(ms_item[31:0], ms_item[63:32]));
        else n_pass++;
      end
    end
    flush = 1'b0;
  endtask

  initial begin
    n_pass = 0; n_total = 0; pc_ctr = 32'h1000;
    rst_n = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_instr = 32'd0; bus.in_pc = 32'd0; bus.out_ready = 1'b0;
    test_reset();
    test_decode();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
